// File: rtl/llr_lrp_tracker_seq_pkg.sv
// ============================================================================
// Module  : llr_lrp_tracker_seq_pkg
// Brief   : Shared helpers and FSM state type for the LRP tracker.
// Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef LLR_LRP_TRACKER_SEQ_PKG_SV
`define LLR_LRP_TRACKER_SEQ_PKG_SV

package llr_lrp_tracker_seq_pkg;

    // Minimum 1 bit so a degenerate count still yields a legal vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } lrp_state_t;

endpackage

`endif
`default_nettype wire

// File: rtl/llr_mag_sat.sv
// ============================================================================
// Module  : llr_mag_sat
// Brief   : Combinational saturated magnitude of a two's-complement LLR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module llr_mag_sat #(
    parameter int LLR_LEN = 4
) (
    input  logic [LLR_LEN-1:0] i_llr,
    output logic [LLR_LEN-2:0] o_mag
);

    logic             w_sign;
    logic             w_most_neg;
    logic [LLR_LEN-2:0] w_neg;

    assign w_sign     = i_llr[LLR_LEN-1];
    assign w_most_neg = w_sign & ~(|i_llr[LLR_LEN-2:0]);
    // Low bits of the negation depend only on the low bits of the input.
    assign w_neg      = (~i_llr[LLR_LEN-2:0]) + 1'b1;

    always_comb begin
        o_mag = i_llr[LLR_LEN-2:0];
        if (w_most_neg) begin
            o_mag = '1;
        end else if (w_sign) begin
            o_mag = w_neg;
        end
    end

endmodule

`default_nettype wire

// File: rtl/llr_lrp_tracker_seq.sv
// ============================================================================
// Module  : llr_lrp_tracker_seq
// Brief   : Streaming LLR magnitude plus per-codeword least-reliable-position list.
// Revision: 1.0
// ============================================================================
`default_nettype none

module llr_lrp_tracker_seq
    import llr_lrp_tracker_seq_pkg::*;
#(
    parameter  int LLR_LEN = 4,
    parameter  int CW_LEN  = 15,
    parameter  int LRP_NUM = 2,
    localparam int MAG_W   = LLR_LEN - 1,
    localparam int POS_W   = clog2(CW_LEN)
) (
    input  logic                     clk,
    input  logic                     in_ctr_Arst,
    input  logic                     in_ctr_start,
    input  logic                     in_valid,
    input  logic [LLR_LEN-1:0]       in_llr,
    output logic                     out_in_ready,
    output logic                     out_mag_valid,
    output logic [MAG_W-1:0]         out_llr_mag,
    output logic                     out_lrp_valid,
    input  logic                     in_lrp_ready,
    output logic [LRP_NUM*MAG_W-1:0] out_lrp_mag,
    output logic [LRP_NUM*POS_W-1:0] out_lrp_pos,
    output logic                     out_proto_err
);

    localparam logic [POS_W-1:0] C_LAST_POS = POS_W'(CW_LEN - 1);

    lrp_state_t       r_state;
    lrp_state_t       w_state_nxt;
    logic [POS_W-1:0] r_pos;        // position of the next sample in the open codeword
    logic [POS_W-1:0] w_pos_nxt;
    logic [POS_W-1:0] w_smp_pos;
    logic [MAG_W-1:0] w_mag;
    logic             w_accept;
    logic             w_in_list;
    logic             w_close;

    logic [MAG_W-1:0] r_wmag     [LRP_NUM];
    logic [POS_W-1:0] r_wpos     [LRP_NUM];
    logic [MAG_W-1:0] w_base_mag [LRP_NUM];
    logic [POS_W-1:0] w_base_pos [LRP_NUM];
    logic [MAG_W-1:0] w_ins_mag  [LRP_NUM];
    logic [POS_W-1:0] w_ins_pos  [LRP_NUM];

    llr_mag_sat #(
        .LLR_LEN (LLR_LEN)
    ) u_mag_sat (
        .i_llr (in_llr),
        .o_mag (w_mag)
    );

    // Only the closing sample can stall, and only while the previous result is unread.
    assign out_in_ready = !((r_state == ST_OPEN) && (r_pos == C_LAST_POS) &&
                            out_lrp_valid && !in_lrp_ready);
    assign w_accept     = in_valid & out_in_ready;
    assign w_in_list    = w_accept & (in_ctr_start | (r_state == ST_OPEN));
    assign w_smp_pos    = in_ctr_start ? '0 : r_pos;
    assign w_close      = w_in_list & (w_smp_pos == C_LAST_POS);

    always_ff @(posedge clk or posedge in_ctr_Arst) begin
        if (in_ctr_Arst) begin
            r_state <= ST_IDLE;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        if (w_close) begin
            w_state_nxt = ST_IDLE;
            w_pos_nxt   = '0;
        end else if (w_in_list) begin
            w_state_nxt = ST_OPEN;
            w_pos_nxt   = w_smp_pos + POS_W'(1);
        end
    end

    // A start sample sees a sentinel-filled list so it is inserted in the same cycle.
    for (genvar i = 0; i < LRP_NUM; i++) begin : g_cell
        logic w_lt_cur;

        assign w_base_mag[i] = in_ctr_start ? '1 : r_wmag[i];
        assign w_base_pos[i] = in_ctr_start ? '1 : r_wpos[i];
        assign w_lt_cur      = w_mag < w_base_mag[i];

        if (i == 0) begin : g_head
            assign w_ins_mag[i] = w_lt_cur ? w_mag     : w_base_mag[i];
            assign w_ins_pos[i] = w_lt_cur ? w_smp_pos : w_base_pos[i];
        end else begin : g_body
            logic w_lt_prev;
            assign w_lt_prev    = w_mag < w_base_mag[i-1];
            assign w_ins_mag[i] = w_lt_prev ? w_base_mag[i-1] :
                                  (w_lt_cur ? w_mag : w_base_mag[i]);
            assign w_ins_pos[i] = w_lt_prev ? w_base_pos[i-1] :
                                  (w_lt_cur ? w_smp_pos : w_base_pos[i]);
        end
    end

    always_ff @(posedge clk or posedge in_ctr_Arst) begin
        if (in_ctr_Arst) begin
            for (int i = 0; i < LRP_NUM; i++) begin
                r_wmag[i] <= '1;
                r_wpos[i] <= '1;
            end
        end else if (w_close) begin
            for (int i = 0; i < LRP_NUM; i++) begin
                r_wmag[i] <= '1;
                r_wpos[i] <= '1;
            end
        end else if (w_in_list) begin
            for (int i = 0; i < LRP_NUM; i++) begin
                r_wmag[i] <= w_ins_mag[i];
                r_wpos[i] <= w_ins_pos[i];
            end
        end
    end

    always_ff @(posedge clk or posedge in_ctr_Arst) begin
        if (in_ctr_Arst) begin
            out_llr_mag   <= '1;
            out_mag_valid <= 1'b0;
            out_proto_err <= 1'b0;
            out_lrp_valid <= 1'b0;
            out_lrp_mag   <= '0;
            out_lrp_pos   <= '0;
        end else begin
            out_mag_valid <= w_accept;
            out_proto_err <= w_accept & ~in_ctr_start & (r_state == ST_IDLE);
            if (w_accept) begin
                out_llr_mag <= w_mag;
            end
            if (w_close) begin
                out_lrp_valid <= 1'b1;
                for (int i = 0; i < LRP_NUM; i++) begin
                    out_lrp_mag[i*MAG_W +: MAG_W] <= w_ins_mag[i];
                    out_lrp_pos[i*POS_W +: POS_W] <= w_ins_pos[i];
                end
            end else if (in_lrp_ready) begin
                out_lrp_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_llr_lrp_tracker_seq.sv
// ============================================================================
// Module  : tb_llr_lrp_tracker_seq
// Brief   : Scoreboard bench for llr_lrp_tracker_seq with a sort-based reference.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_llr_lrp_tracker_seq;

    localparam int LLR_LEN = 4;
    localparam int CW_LEN  = 8;
    localparam int LRP_NUM = 2;
    localparam int MAG_W   = LLR_LEN - 1;
    localparam int POS_W   = 3;
    localparam int MAXM    = (1 << MAG_W) - 1;
    localparam int NC      = LRP_NUM + CW_LEN;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_ctr_start = 1'b0;
    logic                     in_valid = 1'b0;
    logic [LLR_LEN-1:0]       in_llr = '0;
    logic                     out_in_ready;
    logic                     out_mag_valid;
    logic [MAG_W-1:0]         out_llr_mag;
    logic                     out_lrp_valid;
    logic                     in_lrp_ready = 1'b1;
    logic [LRP_NUM*MAG_W-1:0] out_lrp_mag;
    logic [LRP_NUM*POS_W-1:0] out_lrp_pos;
    logic                     out_proto_err;

    llr_lrp_tracker_seq #(
        .LLR_LEN (LLR_LEN),
        .CW_LEN  (CW_LEN),
        .LRP_NUM (LRP_NUM)
    ) dut (
        .clk           (clk),
        .in_ctr_Arst   (rst),
        .in_ctr_start  (in_ctr_start),
        .in_valid      (in_valid),
        .in_llr        (in_llr),
        .out_in_ready  (out_in_ready),
        .out_mag_valid (out_mag_valid),
        .out_llr_mag   (out_llr_mag),
        .out_lrp_valid (out_lrp_valid),
        .in_lrp_ready  (in_lrp_ready),
        .out_lrp_mag   (out_lrp_mag),
        .out_lrp_pos   (out_lrp_pos),
        .out_proto_err (out_proto_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [MAG_W-1:0]         q_mag  [$];
    logic                     q_err  [$];
    logic [LRP_NUM*MAG_W-1:0] q_lmag [$];
    logic [LRP_NUM*POS_W-1:0] q_lpos [$];

    bit rand_ready = 1'b0;
    bit m_open     = 1'b0;
    int m_cnt      = 0;
    int m_mags [CW_LEN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int ref_mag(input logic [LLR_LEN-1:0] llr);
        int v;
        v = int'(llr);
        if (llr[LLR_LEN-1]) v = v - (1 << LLR_LEN);
        if (v < 0) v = -v;
        if (v > MAXM) v = MAXM;
        return v;
    endfunction

    // Rank sentinels ahead of the samples, then stable-select the smallest LRP_NUM.
    task automatic build_result();
        int cm [NC];
        int cp [NC];
        bit used [NC];
        int best;
        logic [LRP_NUM*MAG_W-1:0] lm;
        logic [LRP_NUM*POS_W-1:0] lp;
        for (int k = 0; k < NC; k++) begin
            used[k] = 1'b0;
            cm[k] = (k < LRP_NUM) ? MAXM : m_mags[k-LRP_NUM];
            cp[k] = (k < LRP_NUM) ? (1 << POS_W) - 1 : k - LRP_NUM;
        end
        lm = '0;
        lp = '0;
        for (int k = 0; k < LRP_NUM; k++) begin
            best = -1;
            for (int j = 0; j < NC; j++) begin
                if (!used[j] && (best < 0 || cm[j] < cm[best])) best = j;
            end
            used[best] = 1'b1;
            lm[k*MAG_W +: MAG_W] = MAG_W'(cm[best]);
            lp[k*POS_W +: POS_W] = POS_W'(cp[best]);
        end
        q_lmag.push_back(lm);
        q_lpos.push_back(lp);
    endtask

    task automatic model_accept(input logic st, input logic [LLR_LEN-1:0] llr);
        int m;
        m = ref_mag(llr);
        q_mag.push_back(MAG_W'(m));
        q_err.push_back(!st && !m_open);
        if (st) begin
            m_open = 1'b1;
            m_cnt  = 0;
        end
        if (st || m_open) begin
            m_mags[m_cnt] = m;
            m_cnt++;
            if (m_cnt == CW_LEN) begin
                build_result();
                m_open = 1'b0;
            end
        end
    endtask

    task automatic send(input logic st, input logic [LLR_LEN-1:0] llr);
        int  waitc;
        logic rdy;
        waitc        = 0;
        in_valid     = 1'b1;
        in_ctr_start = st;
        in_llr       = llr;
        forever begin
            @(negedge clk);
            rdy = out_in_ready;
            @(posedge clk);
            if (rdy) break;
            waitc++;
            if (waitc > 500) break;
        end
        if (rdy) model_accept(st, llr);
        else fail_now("accept_timeout");
        #1;
        in_valid     = 1'b0;
        in_ctr_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_list(input int vals [CW_LEN], input int n, input logic first_start);
        for (int s = 0; s < n; s++) begin
            send(first_start && (s == 0), LLR_LEN'(vals[s]));
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_mag_valid) begin
                    if (q_mag.size() == 0) begin
                        fail_now("unexpected_mag");
                    end else begin
                        check("mag", out_llr_mag, q_mag.pop_front());
                        check("proto_err", out_proto_err, q_err.pop_front());
                    end
                end else begin
                    check("proto_err_idle", out_proto_err, 1'b0);
                end
                if (out_lrp_valid) begin
                    if (q_lmag.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        check("lrp_mag", out_lrp_mag, q_lmag[0]);
                        check("lrp_pos", out_lrp_pos, q_lpos[0]);
                        if (in_lrp_ready) begin
                            void'(q_lmag.pop_front());
                            void'(q_lpos.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) in_lrp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_llr_mag"}, out_llr_mag, MAXM);
        check({tag, "_mag_valid"}, out_mag_valid, 1'b0);
        check({tag, "_lrp_valid"}, out_lrp_valid, 1'b0);
        check({tag, "_proto_err"}, out_proto_err, 1'b0);
        check({tag, "_lrp_mag"}, out_lrp_mag, 0);
        check({tag, "_lrp_pos"}, out_lrp_pos, 0);
        check({tag, "_in_ready"}, out_in_ready, 1'b1);
    endtask

    int cw_a [CW_LEN] = '{5, -3, 2, 7, -1, 4, 6, -2};
    int cw_b [CW_LEN] = '{3, 1, -4, 0, 5, -6, 2, -1};
    int cw_c [CW_LEN] = '{6, -5, 3, -7, 2, -2, 5, 4};
    int mags1 [5]     = '{7, -1, -8, 0, -3};

    initial begin
        // Reset state
        #12;
        check_reset_values("reset");
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Magnitudes on idle samples: each also pulses proto_err
        for (int i = 0; i < 5; i++) send(1'b0, LLR_LEN'(mags1[i]));
        idle(1);
        check("mag_valid_drop", out_mag_valid, 1'b0);

        // Basic codeword, tie with a later position loses
        send_list(cw_a, CW_LEN - 1, 1'b1);
        check("no_early_result", out_lrp_valid, 1'b0);
        send(1'b0, LLR_LEN'(cw_a[CW_LEN-1]));
        check("cw_a_valid", out_lrp_valid, 1'b1);
        check("cw_a_mag", out_lrp_mag, {3'd2, 3'd1});
        check("cw_a_pos", out_lrp_pos, {3'd2, 3'd4});
        idle(2);

        // Back-pressure on the closing sample
        in_lrp_ready = 1'b0;
        send_list(cw_a, CW_LEN, 1'b1);
        send_list(cw_b, CW_LEN - 1, 1'b1);
        fork
            send(1'b0, LLR_LEN'(cw_b[CW_LEN-1]));
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("ready_blocked", out_in_ready, 1'b0);
                    check("held_mag", out_lrp_mag, {3'd2, 3'd1});
                end
                @(posedge clk);
                #1;
                in_lrp_ready = 1'b1;
            end
        join
        check("cw_b_valid", out_lrp_valid, 1'b1);
        check("cw_b_mag", out_lrp_mag, {3'd1, 3'd0});
        check("cw_b_pos", out_lrp_pos, {3'd1, 3'd3});
        idle(2);

        // Restart mid-codeword discards the open one
        for (int s = 0; s < 3; s++) send(s == 0, LLR_LEN'(cw_a[s]));
        send_list(cw_c, CW_LEN - 1, 1'b1);
        check("abort_no_result", out_lrp_valid, 1'b0);
        send(1'b0, LLR_LEN'(cw_c[CW_LEN-1]));
        check("cw_c_mag", out_lrp_mag, {3'd2, 3'd2});
        check("cw_c_pos", out_lrp_pos, {3'd5, 3'd4});
        idle(2);

        // Asynchronous reset between edges with a held result and an open codeword
        in_lrp_ready = 1'b0;
        send_list(cw_a, CW_LEN, 1'b1);
        send(1'b1, LLR_LEN'(3));
        send(1'b0, LLR_LEN'(1));
        #2;
        rst = 1'b1;
        q_mag.delete();
        q_err.delete();
        q_lmag.delete();
        q_lpos.delete();
        m_open = 1'b0;
        #1;
        check_reset_values("async_rst");
        #5;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, LLR_LEN'(-6));
        check("post_rst_err", out_proto_err, 1'b1);
        idle(3);
        check("post_rst_no_result", out_lrp_valid, 1'b0);
        in_lrp_ready = 1'b1;
        idle(1);

        // Random traffic with gaps, aborts, stray samples and random consumer stalls
        rand_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            int n;
            n = ($urandom_range(0, 19) == 0) ? $urandom_range(1, CW_LEN - 1) : CW_LEN;
            for (int s = 0; s < n; s++) begin
                send(s == 0, LLR_LEN'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 29) == 0) send(1'b0, LLR_LEN'($urandom));
        end

        // Drain
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        in_lrp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (q_lmag.size() == 0 && q_mag.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("drain_results", q_lmag.size(), 0);
        check("drain_mags", q_mag.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
